ram_burst_master: RTL and testbench

- Initiator front end for one port of the single-clock dual-port parser RAM. The RAM has 1-cycle registered read data.
- Accepts single-word write requests and multi-word read-burst requests over a valid/ready request channel.
- Sequences the chip-select, write-enable, output-enable, address and data pins of the RAM port.
- Returns read words on a valid/ready response channel with backpressure. Used by the FIX field store/lookup logic in place of driving RAM pins directly.

---
 rtl/ram_burst_master_if.sv | 36 +++
 rtl/ram_burst_master.sv | 115 +++++++++++
 tb/tb_ram_burst_master.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_master_if.sv
// ram_burst_master_if: request, response and RAM-pin bundle for ram_burst_master
// Ports: req_* request channel, rsp_* response channel, ram_* RAM port pins.
// Modports: master = the burst master itself, slave = its environment (requester, consumer, RAM).
interface ram_burst_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_cs;
  logic                  ram_we;
  logic                  ram_oe;
  modport master (
    input  req_valid, req_we, req_addr, req_len, req_wdata, rsp_ready, ram_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
           ram_address, ram_wdata, ram_cs, ram_we, ram_oe
  );
  modport slave (
    output req_valid, req_we, req_addr, req_len, req_wdata, rsp_ready, ram_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
           ram_address, ram_wdata, ram_cs, ram_we, ram_oe
  );
endinterface

// File: rtl/ram_burst_master.sv
// ram_burst_master: valid/ready front end sequencing single writes and read bursts on one RAM port
// Ports: clk; reset (synchronous, active-high); bus (ram_burst_master_if.master) with the
//   req_* request channel, rsp_* response channel and registered ram_* pins.
// Optional: define RAM_BOUNDARY_CHECK_EN to reject read bursts that run past the top of RAM.
module ram_burst_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input logic                clk,
  input logic                reset,
  ram_burst_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  localparam int EW = DATA_WIDTH + 2;
  state_t                r_state, w_state_nx;
  logic [ADDR_WIDTH-1:0] r_addr, r_ram_address, w_iss_addr;
  logic [LEN_WIDTH-1:0]  r_rem, w_len, w_iss_rem;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic                  r_ram_cs, r_ram_we, r_ram_oe, r_rd_last, r_cap, r_cap_last;
  logic [EW-1:0]         r_fifo [2];
  logic                  r_wp, r_rp;
  logic [1:0]            r_cnt;
  logic [2:0]            w_used;
  logic [EW-1:0]         w_pdata;
  logic                  w_accept, w_reject, w_rej_acc, w_issue, w_wr, w_iss_last;
  logic                  w_rd_pin, w_credit, w_push, w_pop;
  assign bus.req_ready = (r_state == IDLE) && !reset;
  assign w_accept = bus.req_valid && bus.req_ready;
  assign w_len = (bus.req_len == '0) ? LEN_WIDTH'(1) : bus.req_len;
  // The first read of a burst is issued straight from the accept edge.
  assign w_iss_addr = (r_state == IDLE) ? bus.req_addr : r_addr;
  assign w_iss_rem = (r_state == IDLE) ? w_len : r_rem;
  assign w_iss_last = (w_iss_rem == LEN_WIDTH'(1));
  // Outstanding words: FIFO entries, read on the pins now, and read data being captured now.
  assign w_rd_pin = r_ram_cs && r_ram_oe;
  assign w_used = {1'b0, r_cnt} + {2'b0, w_rd_pin} + {2'b0, r_cap};
  assign w_credit = w_used < 3'd2;
`ifdef RAM_BOUNDARY_CHECK_EN
  logic [ADDR_WIDTH:0] w_end;
  assign w_end = {1'b0, bus.req_addr} + (ADDR_WIDTH+1)'(w_len) - (ADDR_WIDTH+1)'(1);
  assign w_reject = !bus.req_we && w_end[ADDR_WIDTH];
`else
  assign w_reject = 1'b0;
`endif
  assign w_rej_acc = w_accept && w_reject;
  assign w_push = r_cap || w_rej_acc;
  assign w_pdata = w_rej_acc ? {2'b11, {DATA_WIDTH{1'b0}}} : {1'b0, r_cap_last, bus.ram_rdata};
  assign w_pop = (r_cnt != 2'd0) && bus.rsp_ready;
  assign bus.rsp_valid = (r_cnt != 2'd0);
  assign {bus.rsp_err, bus.rsp_last, bus.rsp_data} = r_fifo[r_rp];
  assign bus.ram_cs = r_ram_cs;
  assign bus.ram_we = r_ram_we;
  assign bus.ram_oe = r_ram_oe;
  assign bus.ram_address = r_ram_address;
  assign bus.ram_wdata = r_ram_wdata;
  always_comb begin
    w_state_nx = r_state;
    w_wr = 1'b0;
    w_issue = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        w_wr = bus.req_we;
        w_issue = !bus.req_we && !w_reject;
        w_state_nx = bus.req_we ? WRITE : (w_reject || w_iss_last) ? DRAIN : READ;
      end
      WRITE: w_state_nx = IDLE;
      READ: begin
        w_issue = w_credit;
        w_state_nx = (w_credit && w_iss_last) ? DRAIN : READ;
      end
      default: w_state_nx = (r_cnt == 2'd0 && !w_rd_pin && !r_cap) ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_rem <= '0;
      r_ram_address <= '0;
      r_ram_wdata <= '0;
      r_ram_cs <= 1'b0;
      r_ram_we <= 1'b0;
      r_ram_oe <= 1'b0;
      r_rd_last <= 1'b0;
      r_cap <= 1'b0;
      r_cap_last <= 1'b0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ram_cs <= w_issue || w_wr;
      r_ram_we <= w_wr;
      r_ram_oe <= w_issue;
      r_rd_last <= w_iss_last;
      r_cap <= w_rd_pin;
      r_cap_last <= r_rd_last;
      if (w_issue || w_wr) r_ram_address <= w_iss_addr;
      if (w_wr) r_ram_wdata <= bus.req_wdata;
      if (w_issue) begin
        r_addr <= w_iss_addr + ADDR_WIDTH'(1);
        r_rem <= w_iss_rem - LEN_WIDTH'(1);
      end
      if (w_push) begin
        r_fifo[r_wp] <= w_pdata;
        r_wp <= !r_wp;
      end
      if (w_pop) r_rp <= !r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: scoreboard bench for ram_burst_master with a registered-read RAM model
module tb_ram_burst_master;
  logic        clk = 1'b0;
  logic        reset;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] model [256];
  logic [31:0] mem [256];
  logic [33:0] exp_q [$];
  logic [7:0]  rd_q [$];
  ram_burst_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LEN_WIDTH(4)) bus ();
  ram_burst_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LEN_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_we) mem[bus.ram_address] <= bus.ram_wdata;
    if (bus.ram_cs && bus.ram_oe) bus.ram_rdata <= mem[bus.ram_address];
    if (bus.ram_cs && bus.ram_oe && !bus.ram_we) rd_q.push_back(bus.ram_address);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_req(input logic we, input logic [7:0] a, input logic [3:0] l, input logic [31:0] d);
    int w = 0;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_len = l;
    bus.req_wdata = d;
    while (!bus.req_ready && w < 50) begin
      tick();
      w++;
    end
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL req_accept_timeout got req_ready=%b exp 1", bus.req_ready);
    else n_pass++;
    tick();
    bus.req_valid = 1'b0;
  endtask
  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    send_req(1'b1, a, 4'd0, d);
    model[a] = d;
    n_checks++;
    if ({bus.ram_cs, bus.ram_we, bus.ram_oe, bus.ram_address, bus.ram_wdata} !== {3'b110, a, d})
      $display("FAIL write_pins got cs/we/oe=%b%b%b addr=%h data=%h exp 110 addr=%h data=%h",
               bus.ram_cs, bus.ram_we, bus.ram_oe, bus.ram_address, bus.ram_wdata, a, d);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.ram_cs !== 1'b0)
      $display("FAIL write_done got req_ready=%b ram_cs=%b exp 1 0", bus.req_ready, bus.ram_cs);
    else n_pass++;
  endtask
  task automatic push_burst(input logic [7:0] a, input logic [3:0] l);
    int n;
    n = (l == 4'd0) ? 1 : int'(l);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, i == n - 1, model[8'(int'(a) + i)]});
  endtask
  task automatic run_read(input logic [7:0] a, input logic [3:0] l, input int stall,
                          output int first_lat, output int rd_before, output int base);
    int cyc = 1;
    int w = 0;
    int extra = 0;
    logic [33:0] e;
    first_lat = -1;
    rd_before = -1;
    base = rd_q.size();
    bus.rsp_ready = (stall == 0);
    send_req(1'b0, a, l, 32'd0);
    while (exp_q.size() > 0 && cyc < 200) begin
      if (bus.rsp_valid && first_lat < 0) first_lat = cyc;
      if (first_lat >= 0 && cyc == first_lat + stall) begin
        bus.rsp_ready = 1'b1;
        rd_before = rd_q.size() - base;
      end
      if (bus.rsp_valid) begin
        n_checks++;
        if (bus.rsp_ready) begin
          e = exp_q.pop_front();
          if ({bus.rsp_err, bus.rsp_last, bus.rsp_data} !== e)
            $display("FAIL rsp_beat got err=%b last=%b data=%h exp err=%b last=%b data=%h",
                     bus.rsp_err, bus.rsp_last, bus.rsp_data, e[33], e[32], e[31:0]);
          else n_pass++;
        end else if (bus.rsp_data !== exp_q[0][31:0])
          $display("FAIL rsp_hold got data=%h exp %h", bus.rsp_data, exp_q[0][31:0]);
        else n_pass++;
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL rsp_timeout got %0d beats missing exp 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
    while (!bus.req_ready && w < 20) begin
      if (bus.rsp_valid) extra++;
      tick();
      w++;
    end
    n_checks++;
    if (extra != 0 || bus.req_ready !== 1'b1)
      $display("FAIL burst_end got extra=%0d req_ready=%b exp 0 1", extra, bus.req_ready);
    else n_pass++;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_len = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus.req_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", bus.req_ready);
    else n_pass++;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_last, bus.rsp_err, bus.rsp_data, bus.ram_cs, bus.ram_we, bus.ram_oe,
         bus.ram_address, bus.ram_wdata} !== 78'd0)
      $display("FAIL reset_outputs got rsp_valid=%b cs=%b addr=%h rsp_data=%h exp all 0",
               bus.rsp_valid, bus.ram_cs, bus.ram_address, bus.rsp_data);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
      $display("FAIL reset_release got req_ready=%b rsp_valid=%b exp 1 0", bus.req_ready, bus.rsp_valid);
    else n_pass++;
  endtask
  task automatic test_write_read();
    int lat, rb, base;
    do_write(8'h10, 32'hDEADBEEF);
    push_burst(8'h10, 4'd1);
    run_read(8'h10, 4'd1, 0, lat, rb, base);
    n_checks++;
    if (lat != 3 || rd_q.size() - base != 1)
      $display("FAIL single_read got latency=%0d reads=%0d exp 3 1", lat, rd_q.size() - base);
    else n_pass++;
  endtask
  task automatic test_burst();
    int lat, rb, base;
    for (int i = 0; i < 4; i++) do_write(8'(8'h20 + i), 32'(i + 1));
    push_burst(8'h20, 4'd4);
    run_read(8'h20, 4'd4, 0, lat, rb, base);
    n_checks++;
    if (lat != 3 || rd_q.size() - base != 4)
      $display("FAIL burst4 got latency=%0d reads=%0d exp 3 4", lat, rd_q.size() - base);
    else n_pass++;
    n_checks++;
    if (rd_q.size() - base != 4 ||
        {rd_q[base], rd_q[base + 1], rd_q[base + 2], rd_q[base + 3]} !== 32'h20212223)
      $display("FAIL burst4_addrs got %0d reads exp addresses 20 21 22 23", rd_q.size() - base);
    else n_pass++;
  endtask
  task automatic test_backpressure();
    int lat, rb, base;
    push_burst(8'h20, 4'd4);
    run_read(8'h20, 4'd4, 5, lat, rb, base);
    n_checks++;
    if (rb < 0 || rb > 2) $display("FAIL stall_credit got %0d reads before release exp <=2", rb);
    else n_pass++;
    n_checks++;
    if (rd_q.size() - base != 4) $display("FAIL stall_reads got %0d exp 4", rd_q.size() - base);
    else n_pass++;
  endtask
  task automatic test_wrap();
    int lat, rb, base;
    do_write(8'hFE, 32'hA0A0A0A0);
    do_write(8'hFF, 32'hB1B1B1B1);
    do_write(8'h00, 32'hC2C2C2C2);
`ifdef RAM_BOUNDARY_CHECK_EN
    exp_q.push_back({2'b11, 32'd0});
    run_read(8'hFE, 4'd3, 0, lat, rb, base);
    n_checks++;
    if (lat != 1 || rd_q.size() - base != 0)
      $display("FAIL reject got latency=%0d reads=%0d exp 1 0", lat, rd_q.size() - base);
    else n_pass++;
`else
    push_burst(8'hFE, 4'd3);
    run_read(8'hFE, 4'd3, 0, lat, rb, base);
    n_checks++;
    if (rd_q.size() - base != 3 || {rd_q[base], rd_q[base + 1], rd_q[base + 2]} !== 24'hFEFF00)
      $display("FAIL wrap_addrs got %0d reads exp addresses fe ff 00", rd_q.size() - base);
    else n_pass++;
`endif
  endtask
  task automatic test_len0();
    int lat, rb, base;
    do_write(8'h05, 32'h5555AAAA);
    push_burst(8'h05, 4'd0);
    run_read(8'h05, 4'd0, 0, lat, rb, base);
    n_checks++;
    if (lat != 3 || rd_q.size() - base != 1)
      $display("FAIL len0 got latency=%0d reads=%0d exp 3 1", lat, rd_q.size() - base);
    else n_pass++;
  endtask
  task automatic test_reset_mid();
    int n = 0;
    int w = 0;
    int lat, rb, base;
    bus.rsp_ready = 1'b0;
    send_req(1'b0, 8'h40, 4'd8, 32'd0);
    while (w < 20) begin
      if (bus.ram_cs && bus.ram_oe) n++;
      if (n == 2) break;
      tick();
      w++;
    end
    n_checks++;
    if (n != 2) $display("FAIL mid_second_issue got %0d issues exp 2", n);
    else n_pass++;
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.ram_cs !== 1'b0 || bus.req_ready !== 1'b0)
      $display("FAIL mid_reset got rsp_valid=%b ram_cs=%b req_ready=%b exp 0 0 0",
               bus.rsp_valid, bus.ram_cs, bus.req_ready);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
      $display("FAIL mid_release got req_ready=%b rsp_valid=%b exp 1 0", bus.req_ready, bus.rsp_valid);
    else n_pass++;
    push_burst(8'h10, 4'd1);
    run_read(8'h10, 4'd1, 0, lat, rb, base);
    n_checks++;
    if (lat != 3) $display("FAIL post_reset_read got latency=%0d exp 3", lat);
    else n_pass++;
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_burst();
    test_backpressure();
    test_wrap();
    test_len0();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
